// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit simple processor controller:
// ISA field positions, opcodes and the controller state encoding.
package proc_pkg;

  localparam int DW = 9;

  // Instruction word fields
  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int RX_MSB = 5;
  localparam int RX_LSB = 4;
  localparam int RY_MSB = 3;
  localparam int RY_LSB = 2;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB,
    S_DONE
  } state_t;

  // Opcodes that go through the ALU and the G register
  function automatic logic is_alu(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

endpackage

// File: rtl/proc_if.sv
// Controller-side bundle: run/instruction request, register file ports,
// status and flags. master = controller, slave = surrounding system.
interface proc_if #(parameter int DW = proc_pkg::DW) ();

  logic          run;
  logic [DW-1:0] din;
  logic [DW-1:0] rf_rd0_data;
  logic [DW-1:0] rf_rd1_data;
  logic [1:0]    rf_rd0_addr;
  logic [1:0]    rf_rd1_addr;
  logic          rf_wr_en;
  logic [1:0]    rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic          busy;
  logic          done;
  logic          z_flag;
  logic          c_flag;

  modport master (
    input  run, din, rf_rd0_data, rf_rd1_data,
    output rf_rd0_addr, rf_rd1_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
           busy, done, z_flag, c_flag
  );

  modport slave (
    output run, din, rf_rd0_data, rf_rd1_data,
    input  rf_rd0_addr, rf_rd1_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
           busy, done, z_flag, c_flag
  );

endinterface

// File: rtl/proc_alu.sv
// Combinational ALU: add, subtract (a + ~b + 1) and bitwise and.
// Carry is bit DW of the extended sum; for sub it means "no borrow".
module proc_alu
  import proc_pkg::*;
(
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          carry
);

  logic [DW:0] sum;

  // Select the operation; non-ALU opcodes produce zero
  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DW-1:0];
        carry  = sum[DW];
      end
      OP_SUB: begin
        sum    = {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, 1'b1};
        result = sum[DW-1:0];
        carry  = sum[DW];
      end
      OP_AND: begin
        result = a & b;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/proc_ctrl.sv
// Multi-cycle instruction controller for the 9-bit simple processor.
// Optional macro PROC_CTRL_FLAGS_EN builds the registered z/c flags;
// without it both flags are tied low.
module proc_ctrl
  import proc_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  proc_if.master bus
);

  state_t        state, state_next;
  logic [DW-1:0] ir;
  logic [DW-1:0] g;
  logic [2:0]    op;
  logic [1:0]    rx, ry;
  logic [DW-1:0] alu_res;
  logic          alu_carry;
  logic          latch_g;

  logic [1:0]    rd0_addr, rd1_addr, wr_addr;
  logic          wr_en, done_c;
  logic [DW-1:0] wr_data;

  assign op      = ir[OP_MSB:OP_LSB];
  assign rx      = ir[RX_MSB:RX_LSB];
  assign ry      = ir[RY_MSB:RY_LSB];
  assign latch_g = (state == S_EXEC) && is_alu(op);

  // Instruction bits [1:0] carry no meaning
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[1:0];

  proc_alu u_alu (
    .op     (op),
    .a      (bus.rf_rd0_data),
    .b      (bus.rf_rd1_data),
    .result (alu_res),
    .carry  (alu_carry)
  );

  // State, instruction and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ir    <= '0;
      g     <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && bus.run) ir <= bus.din;
      if (latch_g) g <= alu_res;
    end
  end

  // Next state and register file port drive
  always_comb begin
    state_next = state;
    rd0_addr   = '0;
    rd1_addr   = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    done_c     = 1'b0;
    case (state)
      S_IDLE: if (bus.run) state_next = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_MV: begin
            rd0_addr   = ry;
            wr_en      = 1'b1;
            wr_addr    = rx;
            wr_data    = bus.rf_rd0_data;
            state_next = S_DONE;
          end
          OP_MVI: begin
            wr_en      = 1'b1;
            wr_addr    = rx;
            wr_data    = bus.din;
            state_next = S_DONE;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            rd0_addr   = rx;
            rd1_addr   = ry;
            state_next = S_WB;
          end
          default: state_next = S_DONE;
        endcase
      end
      S_WB: begin
        wr_en      = 1'b1;
        wr_addr    = rx;
        wr_data    = g;
        state_next = S_DONE;
      end
      S_DONE: begin
        done_c     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // An abandoned instruction must neither commit its write nor signal done
  assign bus.rf_wr_en    = wr_en & ~rst;
  assign bus.done        = done_c & ~rst;
  assign bus.rf_rd0_addr = rd0_addr;
  assign bus.rf_rd1_addr = rd1_addr;
  assign bus.rf_wr_addr  = wr_addr;
  assign bus.rf_wr_data  = wr_data;
  assign bus.busy        = (state != S_IDLE);

`ifdef PROC_CTRL_FLAGS_EN
  logic z_q, c_q;

  // Flags follow the ALU result at the edge where G is latched
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else if (latch_g) begin
      z_q <= (alu_res == '0);
      c_q <= alu_carry;
    end
  end

  assign bus.z_flag = z_q;
  assign bus.c_flag = c_q;
`else
  logic unused_carry;
  assign unused_carry = alu_carry;
  assign bus.z_flag   = 1'b0;
  assign bus.c_flag   = 1'b0;
`endif

endmodule
